// File: rtl/axi4_sram_slave.sv
// AXI4 slave over a word-addressed SRAM. Independent read and write FSMs share one array;
// reads return whole aligned words, writes apply byte strobes to the aligned word.
module axi4_sram_slave #(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 16,
  parameter int          RD_LAT     = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        awready,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  output logic        wready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  output logic        arready,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int          DEPTH       = 1 << DEPTH_LOG2;
  localparam int          IDX_W       = DEPTH_LOG2;
  localparam logic [3:0]  LAT_INIT    = 4'(RD_LAT - 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [31:0] mem [DEPTH];

  function automatic logic addr_in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return (off >> (DEPTH_LOG2 + 2)) == 32'd0;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  function automatic logic burst_ok(input logic [1:0] b);
    return (b == BURST_FIXED) || (b == BURST_INCR);
  endfunction

  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] b);
    return (b == BURST_INCR) ? a + (32'd1 << size) : a;
  endfunction

  // ---------------- read channel ----------------
  r_state_e    r_state_q, r_state_d;
  logic        arready_q, arready_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] raddr_q, raddr_d;
  logic [7:0]  rlen_q, rlen_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [1:0]  rburst_q, rburst_d;
  logic [7:0]  rbeat_q, rbeat_d;
  logic [3:0]  lat_q, lat_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic [1:0]  fetch_burst;
  logic [31:0] fetch_word;
  logic [31:0] rnext_addr;

  assign fetch_word = mem[word_idx(fetch_addr)];
  assign rnext_addr = step_addr(raddr_q, rsize_q, rburst_q);

  always_comb begin
    r_state_d   = r_state_q;
    rid_d       = rid_q;
    raddr_d     = raddr_q;
    rlen_d      = rlen_q;
    rsize_d     = rsize_q;
    rburst_d    = rburst_q;
    rbeat_d     = rbeat_q;
    lat_d       = lat_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    fetch_en    = 1'b0;
    fetch_addr  = raddr_q;
    fetch_burst = rburst_q;
    case (r_state_q)
      R_IDLE: if (arvalid && arready_q) begin
        rid_d    = arid;
        raddr_d  = araddr;
        rlen_d   = arlen;
        rsize_d  = arsize;
        rburst_d = arburst;
        rbeat_d  = 8'd0;
        lat_d    = LAT_INIT;
        if (RD_LAT == 1) begin
          r_state_d   = R_DATA;
          fetch_en    = 1'b1;
          fetch_addr  = araddr;
          fetch_burst = arburst;
        end else begin
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        lat_d = lat_q - 4'd1;
        // Leave on the cycle the counter reaches zero so rvalid lands RD_LAT cycles after AR.
        if (lat_q <= 4'd1) begin
          r_state_d = R_DATA;
          fetch_en  = 1'b1;
        end
      end
      R_DATA: if (rready) begin
        if (rbeat_q == rlen_q) begin
          r_state_d = R_IDLE;
        end else begin
          rbeat_d    = rbeat_q + 8'd1;
          raddr_d    = rnext_addr;
          fetch_en   = 1'b1;
          fetch_addr = rnext_addr;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    // Beat data is captured into a register so it cannot change under a stall.
    if (fetch_en) begin
      if (!burst_ok(fetch_burst)) begin
        rdata_d = 32'd0;
        rresp_d = RESP_SLVERR;
      end else if (!addr_in_range(fetch_addr)) begin
        rdata_d = 32'd0;
        rresp_d = RESP_DECERR;
      end else begin
        rdata_d = fetch_word;
        rresp_d = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rid_q     <= 4'd0;
      raddr_q   <= 32'd0;
      rlen_q    <= 8'd0;
      rsize_q   <= 3'd0;
      rburst_q  <= 2'd0;
      rbeat_q   <= 8'd0;
      lat_q     <= 4'd0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'd0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rbeat_q   <= rbeat_d;
      lat_q     <= lat_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign arready = arready_q;
  assign rvalid  = (r_state_q == R_DATA);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rid     = rid_q;
  assign rlast   = (r_state_q == R_DATA) && (rbeat_q == rlen_q);

  // ---------------- write channel ----------------
  w_state_e    w_state_q, w_state_d;
  logic        awready_q, awready_d;
  logic [3:0]  wid_q, wid_d;
  logic [31:0] waddr_q, waddr_d;
  logic [7:0]  wlen_q, wlen_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [1:0]  wburst_q, wburst_d;
  logic [7:0]  wbeat_q, wbeat_d;
  logic        w_decerr_q, w_decerr_d;
  logic        w_slverr_q, w_slverr_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        mem_we;
  logic [IDX_W-1:0] mem_idx;

  always_comb begin
    w_state_d  = w_state_q;
    wid_d      = wid_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wsize_d    = wsize_q;
    wburst_d   = wburst_q;
    wbeat_d    = wbeat_q;
    w_decerr_d = w_decerr_q;
    w_slverr_d = w_slverr_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    mem_idx    = word_idx(waddr_q);
    case (w_state_q)
      W_IDLE: if (awvalid && awready_q) begin
        wid_d      = awid;
        waddr_d    = awaddr;
        wlen_d     = awlen;
        wsize_d    = awsize;
        wburst_d   = awburst;
        wbeat_d    = 8'd0;
        w_decerr_d = 1'b0;
        w_slverr_d = !burst_ok(awburst);
        w_state_d  = W_DATA;
      end
      W_DATA: if (wvalid) begin
        if (burst_ok(wburst_q)) begin
          // Gate on reset so an aborting edge never commits a beat.
          if (addr_in_range(waddr_q)) mem_we = reset;
          else                        w_decerr_d = 1'b1;
        end
        if (wlast != (wbeat_q == wlen_q)) w_slverr_d = 1'b1;
        waddr_d = step_addr(waddr_q, wsize_q, wburst_q);
        if (wbeat_q == wlen_q) begin
          w_state_d = W_RESP;
          bresp_d   = w_decerr_d ? RESP_DECERR : (w_slverr_d ? RESP_SLVERR : RESP_OKAY);
        end else begin
          wbeat_d = wbeat_q + 8'd1;
        end
      end
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      wid_q      <= 4'd0;
      waddr_q    <= 32'd0;
      wlen_q     <= 8'd0;
      wsize_q    <= 3'd0;
      wburst_q   <= 2'd0;
      wbeat_q    <= 8'd0;
      w_decerr_q <= 1'b0;
      w_slverr_q <= 1'b0;
      bresp_q    <= 2'd0;
    end else begin
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wid_q      <= wid_d;
      waddr_q    <= waddr_d;
      wlen_q     <= wlen_d;
      wsize_q    <= wsize_d;
      wburst_q   <= wburst_d;
      wbeat_q    <= wbeat_d;
      w_decerr_q <= w_decerr_d;
      w_slverr_q <= w_slverr_d;
      bresp_q    <= bresp_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign awready = awready_q;
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;
  assign bid     = wid_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Randomized and directed bench for axi4_sram_slave against a word-level memory model.
module tb_axi4_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          DLOG = 16;
  localparam int          LAT  = 2;

  logic clock = 1'b0, reset = 1'b0;
  logic awready, awvalid = 1'b0; logic [31:0] awaddr = '0; logic [3:0] awid = '0;
  logic [7:0] awlen = '0; logic [2:0] awsize = '0; logic [1:0] awburst = '0;
  logic wready, wvalid = 1'b0; logic [31:0] wdata = '0; logic [3:0] wstrb = '0; logic wlast = 1'b0;
  logic bvalid, bready = 1'b0; logic [1:0] bresp; logic [3:0] bid;
  logic arready, arvalid = 1'b0; logic [31:0] araddr = '0; logic [3:0] arid = '0;
  logic [7:0] arlen = '0; logic [2:0] arsize = '0; logic [1:0] arburst = '0;
  logic rvalid, rready = 1'b0; logic [31:0] rdata; logic [1:0] rresp; logic rlast; logic [3:0] rid;

  always #5 clock = ~clock;

  axi4_sram_slave #(.ADDR_BASE(BASE), .DEPTH_LOG2(DLOG), .RD_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  int n_cmp = 0, n_err = 0;
  logic [31:0] model [int];
  logic [31:0] rd_data [$]; logic [1:0] rd_resp [$]; logic rd_last [$]; logic [3:0] rd_id [$];
  logic [31:0] wr_data [$]; logic [3:0] wr_strb [$]; logic wr_last [$];
  int stall_bad, first_lat;
  logic [1:0] b_resp; logic [3:0] b_id; logic wready_early;

  // ---- reference model: byte address arithmetic straight from the burst rules ----
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                            input logic [2:0] size, input logic [1:0] burst);
    return (burst == 2'b01) ? a + (32'(i) << size) : a;
  endfunction
  function automatic bit in_rng(input logic [31:0] a);
    return ((a - BASE) / 32'd4) < (32'd1 << DLOG);
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction
  function automatic logic [31:0] m_rdata(input logic [31:0] a, input logic [1:0] burst);
    if (burst > 2'b01 || !in_rng(a)) return 32'h0;
    return model.exists(widx(a)) ? model[widx(a)] : 32'hx;
  endfunction
  function automatic logic [1:0] m_rresp(input logic [31:0] a, input logic [1:0] burst);
    if (burst > 2'b01) return 2'b10;
    return in_rng(a) ? 2'b00 : 2'b11;
  endfunction
  function automatic logic [1:0] m_write(input logic [31:0] addr, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
    bit dec, slv;
    logic [31:0] a, w;
    dec = 0; slv = (burst > 2'b01);
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, i, size, burst);
      if (wr_last[i] != (i == int'(len))) slv = 1;
      if (burst <= 2'b01) begin
        if (!in_rng(a)) dec = 1;
        else begin
          w = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
          for (int b = 0; b < 4; b++) if (wr_strb[i][b]) w[8*b +: 8] = wr_data[i][8*b +: 8];
          model[widx(a)] = w;
        end
      end
    end
    return dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
  endfunction

  task automatic wq_clear();
    wr_data.delete(); wr_strb.delete(); wr_last.delete();
  endtask
  task automatic wq_push(input logic [31:0] d, input logic [3:0] s, input logic l);
    wr_data.push_back(d); wr_strb.push_back(s); wr_last.push_back(l);
  endtask

  // ---- bus drivers (all driving happens 1 time unit after a rising edge) ----
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    int c;
    @(posedge clock); #1;
    awvalid = 1; awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst;
    c = 0; while (!awready && c < 100) begin @(posedge clock); #1; c++; end
    if (!awready) begin
      n_cmp++; n_err++; $display("FAIL aw_timeout: awready=0 required 1"); awvalid = 0; return;
    end
    @(posedge clock); #1; awvalid = 0; wready_early = wready;
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
      wvalid = 1; wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = wr_last[i];
      c = 0; while (!wready && c < 100) begin @(posedge clock); #1; c++; end
      if (!wready) begin
        n_cmp++; n_err++; $display("FAIL w_timeout: wready=0 required 1"); wvalid = 0; return;
      end
      @(posedge clock); #1; wvalid = 0; wlast = 0;
    end
    c = 0; while (!bvalid && c < 100) begin @(posedge clock); #1; c++; end
    if (!bvalid) begin
      n_cmp++; n_err++; $display("FAIL b_timeout: bvalid=0 required 1"); return;
    end
    b_resp = bresp; b_id = bid;
    repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    bready = 1; @(posedge clock); #1; bready = 0;
  endtask

  // rmode: 0 always ready, 1 toggling, 2 random. abort_at >= 0 asserts reset on that beat.
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int rmode, input int abort_at);
    int c; bit stalled; logic [38:0] held;
    rd_data.delete(); rd_resp.delete(); rd_last.delete(); rd_id.delete();
    stall_bad = 0; first_lat = 0; held = '0;
    @(posedge clock); #1;
    arvalid = 1; araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
    c = 0; while (!arready && c < 100) begin @(posedge clock); #1; c++; end
    if (!arready) begin
      n_cmp++; n_err++; $display("FAIL ar_timeout: arready=0 required 1"); arvalid = 0; return;
    end
    @(posedge clock); #1; arvalid = 0;
    first_lat = 1;
    while (!rvalid && first_lat < 40) begin @(posedge clock); #1; first_lat++; end
    if (!rvalid) begin
      n_cmp++; n_err++; $display("FAIL r_timeout: rvalid=0 required 1"); return;
    end
    stalled = 0; c = 0;
    while (rd_data.size() <= int'(len) && c < 3000) begin
      if (rvalid) begin
        if (stalled && {rdata, rresp, rlast, rid} !== held) stall_bad++;
        if (rd_data.size() == abort_at) begin
          reset = 0; rready = 0; @(posedge clock); #1; return;
        end
        rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
        if (rready) begin
          rd_data.push_back(rdata); rd_resp.push_back(rresp);
          rd_last.push_back(rlast); rd_id.push_back(rid);
        end
        stalled = !rready; held = {rdata, rresp, rlast, rid};
      end else rready = 0;
      @(posedge clock); #1; c++;
    end
    rready = 0;
    if (rd_data.size() <= int'(len)) begin
      n_cmp++; n_err++; $display("FAIL r_beats_timeout: got %0d beats required %0d", rd_data.size(), int'(len) + 1);
    end
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset = 0;
    repeat (3) @(posedge clock); #1;
    n_cmp++; if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b required 000000", {arready, awready, wready, rvalid, bvalid, rlast}); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h required 0", rdata); end
    n_cmp++; if ({rresp, bresp, rid, bid} !== 12'h0) begin
      n_err++; $display("FAIL reset_resp_id: got %h required 0", {rresp, bresp, rid, bid}); end
    reset = 1;
    @(posedge clock); #1;
    n_cmp++; if ({arready, awready} !== 2'b11) begin
      n_err++; $display("FAIL reset_release: arready/awready got %b required 11", {arready, awready}); end
  endtask

  task automatic test_single_read();
    logic [1:0] e;
    wq_clear(); wq_push(32'hDEADBEEF, 4'hF, 1'b1);
    axi_write(BASE, 4'h9, 8'd0, 3'd2, 2'b01); e = m_write(BASE, 8'd0, 3'd2, 2'b01);
    n_cmp++; if (b_resp !== e || b_id !== 4'h9) begin
      n_err++; $display("FAIL single_write_b: resp/id got %h/%h required %h/9", b_resp, b_id, e); end
    axi_read(BASE, 4'h5, 8'd0, 3'd2, 2'b01, 0, -1);
    n_cmp++; if (first_lat != LAT) begin n_err++; $display("FAIL single_latency: got %0d required %0d", first_lat, LAT); end
    n_cmp++; if (rd_data.size() != 1 || rd_data[0] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single_rdata: got %h required deadbeef", rd_data[0]); end
    n_cmp++; if ({rd_last[0], rd_id[0], rd_resp[0]} !== {1'b1, 4'h5, 2'b00}) begin
      n_err++; $display("FAIL single_last_id_resp: got %b/%h/%b required 1/5/00", rd_last[0], rd_id[0], rd_resp[0]); end
    n_cmp++; if (rvalid !== 1'b0 || arready !== 1'b1) begin
      n_err++; $display("FAIL single_return_idle: rvalid/arready got %b%b required 01", rvalid, arready); end
  endtask

  task automatic test_incr_burst();
    logic [1:0] e;
    wq_clear();
    for (int i = 0; i < 8; i++) wq_push($urandom(), 4'hF, i == 7);
    axi_write(BASE + 32'h10, 4'h2, 8'd7, 3'd2, 2'b01); e = m_write(BASE + 32'h10, 8'd7, 3'd2, 2'b01);
    n_cmp++; if (b_resp !== e) begin n_err++; $display("FAIL incr_write_b: got %b required %b", b_resp, e); end
    axi_read(BASE + 32'h10, 4'h7, 8'd7, 3'd2, 2'b01, 1, -1);
    n_cmp++; if (rd_data.size() != 8) begin n_err++; $display("FAIL incr_count: got %0d required 8", rd_data.size()); end
    for (int i = 0; i < rd_data.size(); i++) begin
      n_cmp++; if (rd_data[i] !== model[4 + i] || rd_last[i] !== (i == 7) || rd_resp[i] !== 2'b00) begin
        n_err++; $display("FAIL incr_beat%0d: data/last/resp got %h/%b/%b required %h/%b/00",
                          i, rd_data[i], rd_last[i], rd_resp[i], model[4 + i], i == 7); end
    end
    n_cmp++; if (stall_bad != 0) begin n_err++; $display("FAIL incr_stall_stable: got %0d changes required 0", stall_bad); end
  endtask

  task automatic test_strobe_write();
    wq_clear(); wq_push(32'hAABBCCDD, 4'hF, 1'b1);
    axi_write(BASE + 32'h4, 4'h1, 8'd0, 3'd2, 2'b01); void'(m_write(BASE + 32'h4, 8'd0, 3'd2, 2'b01));
    wq_clear(); wq_push(32'h11223344, 4'b0101, 1'b1);
    axi_write(BASE + 32'h4, 4'h3, 8'd0, 3'd2, 2'b01); void'(m_write(BASE + 32'h4, 8'd0, 3'd2, 2'b01));
    n_cmp++; if (wready_early !== 1'b1) begin n_err++; $display("FAIL strobe_wready_timing: got %b required 1", wready_early); end
    n_cmp++; if (b_resp !== 2'b00 || b_id !== 4'h3) begin
      n_err++; $display("FAIL strobe_b: resp/id got %b/%h required 00/3", b_resp, b_id); end
    axi_read(BASE + 32'h4, 4'h0, 8'd0, 3'd2, 2'b00, 0, -1);
    n_cmp++; if (rd_data[0] !== 32'hAA22CC44) begin n_err++; $display("FAIL strobe_rdata: got %h required aa22cc44", rd_data[0]); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] oor;
    oor = BASE + (32'd4 << DLOG);
    axi_read(oor, 4'hA, 8'd1, 3'd2, 2'b01, 2, -1);
    n_cmp++; if (rd_data.size() != 2) begin n_err++; $display("FAIL oor_count: got %0d required 2", rd_data.size()); end
    for (int i = 0; i < rd_data.size(); i++) begin
      n_cmp++; if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'b11) begin
        n_err++; $display("FAIL oor_beat%0d: data/resp got %h/%b required 0/11", i, rd_data[i], rd_resp[i]); end
    end
    wq_clear(); wq_push(32'h5A5A5A5A, 4'hF, 1'b1);
    axi_write(oor, 4'hB, 8'd0, 3'd2, 2'b01);
    n_cmp++; if (b_resp !== m_write(oor, 8'd0, 3'd2, 2'b01)) begin n_err++; $display("FAIL oor_bresp: got %b required 11", b_resp); end
    axi_read(BASE, 4'h0, 8'd0, 3'd2, 2'b01, 0, -1);
    n_cmp++; if (rd_data[0] !== model[0]) begin n_err++; $display("FAIL oor_no_alias: word0 got %h required %h", rd_data[0], model[0]); end
  endtask

  task automatic test_errors();
    logic [1:0] e;
    wq_clear();
    for (int i = 0; i < 4; i++) wq_push($urandom(), 4'hF, i == 1);
    axi_write(BASE + 32'h50, 4'h4, 8'd3, 3'd2, 2'b01); e = m_write(BASE + 32'h50, 8'd3, 3'd2, 2'b01);
    n_cmp++; if (b_resp !== e || e !== 2'b10) begin n_err++; $display("FAIL early_wlast_bresp: got %b required 10", b_resp); end
    axi_read(BASE + 32'h50, 4'h4, 8'd3, 3'd2, 2'b01, 0, -1);
    n_cmp++; if (rd_data.size() != 4 || rd_data[3] !== model[23]) begin
      n_err++; $display("FAIL early_wlast_all_beats: last word got %h required %h", rd_data[3], model[23]); end
    axi_read(BASE + 32'h10, 4'hC, 8'd3, 3'd2, 2'b10, 0, -1);
    n_cmp++; if (rd_data.size() != 4 || rd_last[3] !== 1'b1) begin
      n_err++; $display("FAIL wrap_read_count: got %0d beats required 4", rd_data.size()); end
    for (int i = 0; i < rd_resp.size(); i++) begin
      n_cmp++; if (rd_resp[i] !== m_rresp(BASE + 32'h10, 2'b10)) begin
        n_err++; $display("FAIL wrap_read_rresp%0d: got %b required 10", i, rd_resp[i]); end
    end
    wq_clear(); wq_push(32'h0BAD0BAD, 4'hF, 1'b0); wq_push(32'h0BAD0BAD, 4'hF, 1'b1);
    axi_write(BASE + 32'h10, 4'hD, 8'd1, 3'd2, 2'b10); e = m_write(BASE + 32'h10, 8'd1, 3'd2, 2'b10);
    n_cmp++; if (b_resp !== e) begin n_err++; $display("FAIL wrap_write_bresp: got %b required %b", b_resp, e); end
    axi_read(BASE + 32'h10, 4'h0, 8'd0, 3'd2, 2'b01, 0, -1);
    n_cmp++; if (rd_data[0] !== model[4]) begin n_err++; $display("FAIL wrap_write_no_mem: got %h required %h", rd_data[0], model[4]); end
  endtask

  task automatic test_len255();
    int nlast;
    axi_read(BASE, 4'hE, 8'd255, 3'd2, 2'b00, 0, -1);
    n_cmp++; if (rd_data.size() != 256) begin n_err++; $display("FAIL len255_count: got %0d required 256", rd_data.size()); end
    nlast = 0;
    foreach (rd_last[i]) if (rd_last[i] === 1'b1) nlast++;
    n_cmp++; if (nlast != 1 || rd_last[255] !== 1'b1) begin
      n_err++; $display("FAIL len255_rlast: %0d rlast beats, final=%b required 1 and 1", nlast, rd_last[255]); end
    n_cmp++; if (rd_data[128] !== model[0]) begin n_err++; $display("FAIL len255_fixed_data: got %h required %h", rd_data[128], model[0]); end
  endtask

  task automatic test_random();
    logic [31:0] a; logic [7:0] len; logic [2:0] size; logic [1:0] burst, e; logic [3:0] id;
    wq_clear();
    for (int i = 0; i < 64; i++) wq_push($urandom(), 4'hF, i == 63);
    axi_write(BASE + 32'h80, 4'h6, 8'd63, 3'd2, 2'b01); e = m_write(BASE + 32'h80, 8'd63, 3'd2, 2'b01);
    n_cmp++; if (b_resp !== e) begin n_err++; $display("FAIL rand_fill_bresp: got %b required %b", b_resp, e); end
    for (int t = 0; t < 24; t++) begin
      a = BASE + 32'h80 + 32'($urandom_range(0, 160));
      len = 8'($urandom_range(0, 15)); size = 3'($urandom_range(0, 2));
      burst = 2'($urandom_range(0, 1)); id = 4'($urandom());
      if ($urandom_range(0, 1) == 0) begin
        wq_clear();
        for (int i = 0; i <= int'(len); i++) wq_push($urandom(), 4'($urandom()), i == int'(len));
        axi_write(a, id, len, size, burst); e = m_write(a, len, size, burst);
        n_cmp++; if (b_resp !== e || b_id !== id) begin
          n_err++; $display("FAIL rand_write%0d: resp/id got %b/%h required %b/%h", t, b_resp, b_id, e, id); end
      end else begin
        axi_read(a, id, len, size, burst, 2, -1);
        n_cmp++; if (rd_data.size() != int'(len) + 1 || stall_bad != 0) begin
          n_err++; $display("FAIL rand_read%0d_shape: beats %0d stall changes %0d required %0d/0", t, rd_data.size(), stall_bad, int'(len) + 1); end
        for (int i = 0; i < rd_data.size(); i++) begin
          n_cmp++;
          if (rd_data[i] !== m_rdata(beat_addr(a, i, size, burst), burst) || rd_resp[i] !== 2'b00 ||
              rd_last[i] !== (i == int'(len)) || rd_id[i] !== id) begin
            n_err++; $display("FAIL rand_read%0d_beat%0d: data/resp/last/id got %h/%b/%b/%h required %h/00/%b/%h",
                              t, i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i],
                              m_rdata(beat_addr(a, i, size, burst), burst), i == int'(len), id); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    axi_read(BASE + 32'h10, 4'h3, 8'd7, 3'd2, 2'b01, 0, 2);
    n_cmp++; if (rvalid !== 1'b0 || arready !== 1'b0) begin
      n_err++; $display("FAIL midreset_abort: rvalid/arready got %b%b required 00", rvalid, arready); end
    reset = 1;
    @(posedge clock); #1;
    n_cmp++; if (arready !== 1'b1 || bvalid !== 1'b0) begin
      n_err++; $display("FAIL midreset_release: arready/bvalid got %b%b required 10", arready, bvalid); end
    axi_read(BASE + 32'h10, 4'h8, 8'd7, 3'd2, 2'b01, 0, -1);
    n_cmp++; if (rd_data.size() != 8 || rd_data[7] !== model[11] || rd_data[0] !== model[4] || rd_id[0] !== 4'h8) begin
      n_err++; $display("FAIL midreset_new_read: first/last got %h/%h required %h/%h", rd_data[0], rd_data[7], model[4], model[11]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_incr_burst();
    test_strobe_write();
    test_out_of_range();
    test_errors();
    test_len255();
    test_random();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi4_sram_slave.md
# axi4_sram_slave

AXI4 responder holding a word-addressed SRAM. It answers the read and write transactions issued by the core's LSU/icache master port, including the icache's INCR read bursts. It serves as the memory behind `io_master_*` in non-SoC simulation builds, and as a loopback target for the core-side slave port. Read and write channels run independent state machines over a shared memory array.

## Interface
Parameters:
- `ADDR_BASE`, 32'h8000_0000, byte address of word 0.
- `DEPTH_LOG2`, 16, log2 of the number of 32-bit words.
- `RD_LAT`, 2, cycles from AR handshake to first `rvalid`; legal range 1..15.

Ports (`clock` is the single clock; `reset` is synchronous and active-low, so the block resets on a rising `clock` edge while `reset` == 0):
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `awready`  out  1  write address accepted.
- `awvalid`  in  1  write address valid.
- `awaddr`  in  32  write start byte address.
- `awid`  in  4  write transaction ID.
- `awlen`  in  8  write beats minus 1.
- `awsize`  in  3  log2 bytes per write beat.
- `awburst`  in  2  write burst type.
- `wready`  out  1  write data accepted.
- `wvalid`  in  1  write data valid.
- `wdata`  in  32  write data.
- `wstrb`  in  4  byte enables.
- `wlast`  in  1  final write beat.
- `bvalid`  out  1  write response valid.
- `bready`  in  1  write response accepted.
- `bresp`  out  2  write response code.
- `bid`  out  4  write response ID.
- `arready`  out  1  read address accepted.
- `arvalid`  in  1  read address valid.
- `araddr`  in  32  read start byte address.
- `arid`  in  4  read transaction ID.
- `arlen`  in  8  read beats minus 1.
- `arsize`  in  3  log2 bytes per read beat.
- `arburst`  in  2  read burst type.
- `rvalid`  out  1  read data valid.
- `rready`  in  1  read data accepted.
- `rdata`  out  32  read data.
- `rresp`  out  2  read response code.
- `rlast`  out  1  final read beat.
- `rid`  out  4  read response ID.

## Operation
- Read FSM states are R_IDLE, R_WAIT and R_DATA.
  - R_IDLE: `arready` is 1. An AR handshake latches id, addr, len, size and burst, loads the latency counter with RD_LAT-1, and moves to R_WAIT (or directly to R_DATA when RD_LAT == 1).
  - R_WAIT: the counter decrements each cycle; at 0 the FSM moves to R_DATA.
  - R_DATA: `rvalid` is 1; `rdata` is the whole aligned word at addr[31:2] and `rid` is the latched ID.
  - `rlast` is 1 when beat == len.
  - On each `rvalid`&`rready` handshake the beat counter increments. For INCR bursts addr += 1<<size; for FIXED bursts addr is unchanged.
  - The last handshake returns the FSM to R_IDLE.
- Write FSM states are W_IDLE, W_DATA and W_RESP.
  - W_IDLE: `awready` is 1; `wready` is 0, so W beats arriving before AW stall.
  - An AW handshake latches the transaction and moves to W_DATA, where `wready` is 1.
  - Each W handshake writes the bytes selected by `wstrb` and advances addr per burst type.
  - The handshake on beat == len moves to W_RESP, where `bvalid` is 1 and `bid` is the latched ID.
  - A B handshake returns the FSM to W_IDLE.
- Response codes:
  - An address is out of range when (addr-ADDR_BASE)>>2 ≥ 2^DEPTH_LOG2 (unsigned). Such a read beat returns `rdata` 0 with `rresp` 2'b11; such a write beat is dropped and forces `bresp` 2'b11.
  - A WRAP or reserved burst type returns SLVERR (2'b10) on every read beat, and `bresp` SLVERR for writes; no memory access occurs. The full len+1 beats are still exchanged.
  - If `wlast` disagrees with the beat count, the transaction still ends on the count and `bresp` is SLVERR unless DECERR already applies (DECERR takes priority).
  - Otherwise every response is OKAY (2'b00).
- Both channels may be active at once. A write committed at clock edge e is visible to any read beat whose word is fetched after e. Same-edge collisions return the old data.
- The memory array is not reset.

## Timing
- Reset values: `arready`, `awready`, `wready`, `rvalid`, `bvalid` and `rlast` are 0; `rdata` is 0; `rresp`, `bresp`, `rid` and `bid` are 0. `arready` and `awready` go to 1 in the first cycle after `reset` returns to 1.
- Reset mid-transaction aborts both FSMs to idle. No response is issued and no further memory writes occur.
- An AR handshake at edge t gives first `rvalid` in cycle t+RD_LAT. Subsequent beats complete one per cycle while `rready` is held at 1.
- `rdata`, `rresp`, `rlast` and `rid` stay stable while `rvalid`&!`rready`.
- Write path: an AW handshake at edge t gives `wready` in cycle t+1. `bvalid` rises in the cycle after the final W handshake and is held until `bready`.
- `arready` is 0 outside R_IDLE; `awready` is 0 outside W_IDLE. Only one outstanding transaction per channel.
- `awlen`/`arlen` of 255 give 256 beats; the beat counter is 8 bits and does not wrap early.

## Test plan
- Single read, RD_LAT=2: preload word 0 with 32'hDEADBEEF; AR addr 8000_0000, len 0, id 5 -> `rvalid` 2 cycles after the handshake, `rdata` DEADBEEF, `rlast` 1, `rid` 5, `rresp` 0.
- INCR read burst: AR addr 8000_0010, len 7, size 2; `rready` toggles 1/0 -> words 4..11 delivered in order, data held while stalled, `rlast` only on beat 8.
- Strobed write then read: AW 8000_0004, W 32'h11223344 with strb 4'b0101 over word 0xAABBCCDD -> `bresp` 0, then read returns AA22CC44.
- Out of range: AR 8000_0000+(4<<DEPTH_LOG2), len 1 -> 2 beats, `rdata` 0, `rresp` 2'b11. Write to the same address -> `bresp` 2'b11, memory unchanged.
- Early `wlast` and WRAP burst: AW len 3 with `wlast` on beat 1 -> 4 beats accepted, `bresp` 2'b10. AR with burst 2'b10 -> `rresp` 2'b10 on all beats.
- Reset mid-burst: assert `reset`=0 during beat 3 of an 8-beat read -> next cycle `rvalid` 0; after release `arready` is 1 and a new read completes normally.
